// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multi-cycle RV32I control sequencer: opcodes,
// state encoding, datapath mux selects and the control-word payload.
package multicycle_control_fsm_pkg;

  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned STATE_W    = 4;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_ALUI   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_ALU    = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_JAL_WB   = 4'd11,
    S_BRANCH   = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_RS1   = 2'd2;
  localparam logic [1:0] SRC_A_ZERO  = 2'd3;

  localparam logic [1:0] SRC_B_RS2   = 2'd0;
  localparam logic [1:0] SRC_B_IMM   = 2'd1;
  localparam logic [1:0] SRC_B_FOUR  = 2'd2;

  localparam logic [1:0] ALU_ADD     = 2'd0;
  localparam logic [1:0] ALU_CMP     = 2'd1;
  localparam logic [1:0] ALU_FUNCT   = 2'd2;

  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEM     = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  // State following DECODE for a given major opcode; unknown opcodes trap.
  function automatic state_e decode_target(input logic [OPCODE_W-1:0] opcode);
    state_e target;
    case (opcode)
      OP_ALU:    target = S_EXEC_R;
      OP_ALUI:   target = S_EXEC_I;
      OP_LOAD:   target = S_MEM_ADDR;
      OP_STORE:  target = S_MEM_ADDR;
      OP_JAL:    target = S_JAL;
      OP_JALR:   target = S_JALR;
      OP_BRANCH: target = S_BRANCH;
      OP_LUI:    target = S_LUI;
      OP_AUIPC:  target = S_WB_ALU;
      default:   target = S_TRAP;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts not-ready cycles of a shared-memory access; expired once the count
// reaches MEM_TIMEOUT, after which the count holds.
module multicycle_control_fsm_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer of the multi-cycle RV32I datapath: steps each
// instruction through fetch/decode/execute/memory/writeback, traps on faults.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [OPCODE_W-1:0]   i_opcode,
  input  logic                  i_mem_ready,
  input  logic                  i_branch_taken,
  output logic [OPCODE_W-1:0]   o_imm_opcode,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic                  o_iord,
  output logic                  o_ir_write,
  output logic                  o_pc_write,
  output logic                  o_reg_write,
  output logic [1:0]            o_alu_src_a,
  output logic [1:0]            o_alu_src_b,
  output logic [1:0]            o_alu_op,
  output logic [1:0]            o_result_src,
  output logic [STATE_W-1:0]    o_state,
  output logic                  o_illegal,
  output logic [INSTRET_W-1:0]  o_instret
);

  state_e state;
  state_e state_next;
  ctrl_t  ctrl;
  ctrl_t  ctrl_gated;
  logic   wait_state;
  logic   wait_expired;
  logic   timer_clear;
  logic   retire;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Timer restarts on every state change, so each wait state starts from zero.
  assign wait_state  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timer_clear = (state_next != state);

  multicycle_control_fsm_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (i_clk),
    .rst     (i_rst),
    .clear   (timer_clear),
    .enable  (wait_state && !i_mem_ready),
    .expired (wait_expired)
  );

  always_comb begin
    state_next = state;
    ctrl       = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read   = 1'b1;
        ctrl.iord       = 1'b0;
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALU;
        if (i_mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_next    = S_DECODE;
        end else if (wait_expired) begin
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_next     = decode_target(i_opcode);
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_FUNCT;
        state_next     = S_WB_ALU;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_FUNCT;
        state_next     = S_WB_ALU;
      end
      S_LUI: begin
        ctrl.alu_src_a = SRC_A_ZERO;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_next     = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_next     = (o_imm_opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (i_mem_ready) begin
          state_next = S_WB_MEM;
        end else if (wait_expired) begin
          state_next = S_TRAP;
        end
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (i_mem_ready) begin
          state_next = S_FETCH;
        end else if (wait_expired) begin
          state_next = S_TRAP;
        end
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        state_next      = S_FETCH;
      end
      S_WB_ALU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        state_next      = S_FETCH;
      end
      S_JAL: begin
        // PC takes the DECODE target while the ALU forms the link address.
        ctrl.pc_write   = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.alu_src_a  = SRC_A_OLDPC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.alu_op     = ALU_ADD;
        state_next      = S_WB_ALU;
      end
      S_JALR: begin
        ctrl.pc_write   = 1'b1;
        ctrl.result_src = RES_ALU;
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.alu_op     = ALU_ADD;
        state_next      = S_JAL_WB;
      end
      S_JAL_WB: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        state_next     = S_WB_ALU;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_RS2;
        ctrl.alu_op     = ALU_CMP;
        ctrl.pc_write   = i_branch_taken;
        ctrl.result_src = RES_ALUOUT;
        state_next      = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_TRAP;
      end
    endcase
  end

  // No strobe or enable may leak out while reset is held.
  assign ctrl_gated   = i_rst ? '0 : ctrl;
  assign o_mem_read   = ctrl_gated.mem_read;
  assign o_mem_write  = ctrl_gated.mem_write;
  assign o_iord       = ctrl_gated.iord;
  assign o_ir_write   = ctrl_gated.ir_write;
  assign o_pc_write   = ctrl_gated.pc_write;
  assign o_reg_write  = ctrl_gated.reg_write;
  assign o_alu_src_a  = ctrl_gated.alu_src_a;
  assign o_alu_src_b  = ctrl_gated.alu_src_b;
  assign o_alu_op     = ctrl_gated.alu_op;
  assign o_result_src = ctrl_gated.result_src;
  assign o_state      = state;

  assign retire = (state_next == S_FETCH) && (state != S_FETCH) && (state != S_TRAP);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_imm_opcode <= '0;
      o_illegal    <= 1'b0;
      o_instret    <= '0;
    end else begin
      if (state == S_DECODE) begin
        o_imm_opcode <= i_opcode;
      end
      if (state_next == S_TRAP) begin
        o_illegal <= 1'b1;
      end
      if (retire) begin
        o_instret <= o_instret + INSTRET_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-cycle expectations are generated from instruction-level
// rules (phase lists per opcode class) and compared against the sequencer outputs.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  localparam int unsigned TMO = 4;
  localparam int unsigned IW  = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [6:0]    i_opcode;
  logic          i_mem_ready;
  logic          i_branch_taken;
  logic [6:0]    o_imm_opcode;
  logic          o_mem_read, o_mem_write, o_iord, o_ir_write, o_pc_write, o_reg_write;
  logic [1:0]    o_alu_src_a, o_alu_src_b, o_alu_op, o_result_src;
  logic [3:0]    o_state;
  logic          o_illegal;
  logic [IW-1:0] o_instret;

  always #5 i_clk = ~i_clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(TMO), .INSTRET_W(IW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_mem_ready(i_mem_ready),
    .i_branch_taken(i_branch_taken), .o_imm_opcode(o_imm_opcode), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_iord(o_iord), .o_ir_write(o_ir_write),
    .o_pc_write(o_pc_write), .o_reg_write(o_reg_write), .o_alu_src_a(o_alu_src_a),
    .o_alu_src_b(o_alu_src_b), .o_alu_op(o_alu_op), .o_result_src(o_result_src),
    .o_state(o_state), .o_illegal(o_illegal), .o_instret(o_instret)
  );

  typedef struct packed {
    logic [6:0]    opcode;
    logic          ready;
    logic          taken;
    logic [3:0]    state;
    logic          mr, mw, iord, irw, pcw, rw;
    logic [1:0]    sa, sb, op, rs;
    logic [6:0]    imm;
    logic          illegal;
    logic [IW-1:0] instret;
  } vec_t;

  vec_t          vec[$];
  vec_t          addi_tab [4];
  int            checks = 0;
  int            errors = 0;
  logic [6:0]    exp_imm;
  logic [IW-1:0] exp_instret;
  logic [6:0]    ops [9] = '{OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_JAL, OP_JALR,
                             OP_BRANCH, OP_LUI, OP_AUIPC};
  int            fw, mw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input int idx, input vec_t v);
    logic [33:0] act, expv;
    act  = {o_state, o_mem_read, o_mem_write, o_iord, o_ir_write, o_pc_write, o_reg_write,
            o_alu_src_a, o_alu_src_b, o_alu_op, o_result_src, o_imm_opcode, o_illegal, o_instret};
    expv = {v.state, v.mr, v.mw, v.iord, v.irw, v.pcw, v.rw,
            v.sa, v.sb, v.op, v.rs, v.imm, v.illegal, v.instret};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s[%0d] exp_state=%0d: got %h expected %h", tag, idx, v.state, act, expv);
    end
  endtask

  // Apply queued cycles: drive at the falling edge, compare 1 time unit later.
  task automatic run_vec(input string tag);
    for (int i = 0; i < vec.size(); i++) begin
      i_opcode       = vec[i].opcode;
      i_mem_ready    = vec[i].ready;
      i_branch_taken = vec[i].taken;
      #1;
      chk_vec(tag, i, vec[i]);
      @(negedge i_clk);
    end
    vec.delete();
  endtask

  function automatic vec_t blank(input state_e st);
    vec_t v;
    v         = '0;
    v.opcode  = 7'($urandom);
    v.ready   = 1'($urandom);
    v.taken   = 1'($urandom);
    v.state   = st;
    v.imm     = exp_imm;
    v.instret = exp_instret;
    return v;
  endfunction

  task automatic push_st(input state_e st, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] op, input logic [1:0] rs,
                         input logic pcw, input logic rw);
    vec_t v;
    v = blank(st);
    v.sa = a; v.sb = b; v.op = op; v.rs = rs; v.pcw = pcw; v.rw = rw;
    vec.push_back(v);
  endtask

  task automatic push_fetch(input int waits);
    vec_t v;
    for (int i = 0; i <= waits; i++) begin
      v = blank(S_FETCH);
      v.ready = (i == waits); v.mr = 1'b1; v.sb = 2'd2; v.rs = 2'd2;
      v.irw = v.ready; v.pcw = v.ready;
      vec.push_back(v);
    end
  endtask

  task automatic push_trap(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = blank(S_TRAP);
      v.illegal = 1'b1;
      vec.push_back(v);
    end
  endtask

  // One whole instruction, phase by phase, from its opcode class.
  task automatic gen_instr(input logic [6:0] opc, input int fwait, input int mwait,
                           input logic taken);
    vec_t v;
    logic legal;
    legal = 1'b1;
    push_fetch(fwait);
    v = blank(S_DECODE);
    v.opcode = opc; v.sa = 2'd1; v.sb = 2'd1;
    vec.push_back(v);
    exp_imm = opc;
    case (opc)
      OP_ALU:   begin push_st(S_EXEC_R, 2'd2, 2'd0, 2'd2, 2'd0, 0, 0); push_st(S_WB_ALU, 0, 0, 0, 0, 0, 1); end
      OP_ALUI:  begin push_st(S_EXEC_I, 2'd2, 2'd1, 2'd2, 2'd0, 0, 0); push_st(S_WB_ALU, 0, 0, 0, 0, 0, 1); end
      OP_LUI:   begin push_st(S_LUI, 2'd3, 2'd1, 2'd0, 2'd0, 0, 0); push_st(S_WB_ALU, 0, 0, 0, 0, 0, 1); end
      OP_AUIPC: push_st(S_WB_ALU, 0, 0, 0, 0, 0, 1);
      OP_JAL:   begin push_st(S_JAL, 2'd1, 2'd2, 2'd0, 2'd0, 1, 0); push_st(S_WB_ALU, 0, 0, 0, 0, 0, 1); end
      OP_JALR: begin
        push_st(S_JALR, 2'd2, 2'd1, 2'd0, 2'd2, 1, 0);
        push_st(S_JAL_WB, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0);
        push_st(S_WB_ALU, 0, 0, 0, 0, 0, 1);
      end
      OP_BRANCH: begin
        v = blank(S_BRANCH);
        v.taken = taken; v.sa = 2'd2; v.sb = 2'd0; v.op = 2'd1; v.pcw = taken;
        vec.push_back(v);
      end
      OP_LOAD, OP_STORE: begin
        push_st(S_MEM_ADDR, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0);
        for (int i = 0; i <= mwait; i++) begin
          v = blank((opc == OP_LOAD) ? S_MEM_RD : S_MEM_WR);
          v.ready = (i == mwait); v.iord = 1'b1;
          v.mr = (opc == OP_LOAD); v.mw = (opc == OP_STORE);
          vec.push_back(v);
        end
        if (opc == OP_LOAD) push_st(S_WB_MEM, 0, 0, 0, 2'd1, 0, 1);
      end
      default: begin
        push_trap(20);
        legal = 1'b0;
      end
    endcase
    if (legal) exp_instret = exp_instret + IW'(1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_mem_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    chk("rst_state", 32'(o_state), 32'(S_FETCH));
    chk("rst_strobes", 32'({o_mem_read, o_mem_write, o_ir_write, o_pc_write, o_reg_write}), 32'd0);
    chk("rst_illegal", 32'(o_illegal), 32'd0);
    chk("rst_instret", 32'(o_instret), 32'd0);
    chk("rst_imm_opcode", 32'(o_imm_opcode), 32'd0);
    i_rst = 1'b0;
    #1;
    chk("rst_release_mem_read", 32'(o_mem_read), 32'd1);
    exp_imm = '0;
    exp_instret = '0;
  endtask

  initial begin
    i_rst = 1'b1; i_opcode = '0; i_mem_ready = 1'b0; i_branch_taken = 1'b0;
    exp_imm = '0; exp_instret = '0;
    do_reset();

    // ADDI 0x00500093 with memory always ready: hand-written expectations.
    addi_tab[0] = '{7'h00, 1'b1, 1'b0, 4'(S_FETCH),  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                    2'd0, 2'd2, 2'd0, 2'd2, 7'h00, 1'b0, 8'd0};
    addi_tab[1] = '{7'h13, 1'b1, 1'b0, 4'(S_DECODE), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'd1, 2'd1, 2'd0, 2'd0, 7'h00, 1'b0, 8'd0};
    addi_tab[2] = '{7'h00, 1'b1, 1'b1, 4'(S_EXEC_I), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'd2, 2'd1, 2'd2, 2'd0, 7'h13, 1'b0, 8'd0};
    addi_tab[3] = '{7'h00, 1'b1, 1'b0, 4'(S_WB_ALU), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                    2'd0, 2'd0, 2'd0, 2'd0, 7'h13, 1'b0, 8'd0};
    for (int i = 0; i < 4; i++) vec.push_back(addi_tab[i]);
    run_vec("addi");
    #1;
    chk("addi_instret", 32'(o_instret), 32'd1);
    chk("addi_imm_opcode", 32'(o_imm_opcode), 32'b0010011);
    chk("addi_back_to_fetch", 32'(o_state), 32'(S_FETCH));
    exp_imm = 7'b0010011;
    exp_instret = 8'd1;

    // LW with three not-ready cycles, then BEQ taken and not taken.
    gen_instr(7'b0000011, 0, 3, 1'b0);
    run_vec("lw");
    gen_instr(7'b1100011, 0, 0, 1'b1);
    run_vec("beq_taken");
    gen_instr(7'b1100011, 1, 0, 1'b0);
    run_vec("beq_not_taken");
    #1;
    chk("beq_instret", 32'(o_instret), 32'd4);

    // Random legal instruction stream; waits include the exact timeout boundary.
    for (int n = 0; n < 300; n++) begin
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TMO)) : 0;
      if (n % 50 == 7) begin fw = TMO; mw = TMO; end
      gen_instr(ops[$urandom_range(0, 8)], fw, mw, 1'($urandom));
    end
    run_vec("rand");
    #1;
    chk("instret_wrap", 32'(o_instret), 32'(IW'(304)));

    // Illegal opcode traps and stays trapped until reset.
    gen_instr(7'b0000000, 0, 0, 1'b0);
    run_vec("illegal");
    do_reset();

    // Fetch never completes: trap once the wait count has reached the limit.
    push_fetch(TMO + 1);
    vec.pop_back();
    push_trap(6);
    run_vec("fetch_timeout");
    do_reset();

    // Reset asserted while a store is waiting on memory.
    push_fetch(0);
    begin
      vec_t v;
      v = blank(S_DECODE); v.opcode = OP_STORE; v.sa = 2'd1; v.sb = 2'd1;
      vec.push_back(v);
    end
    exp_imm = OP_STORE;
    push_st(S_MEM_ADDR, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      vec_t v;
      v = blank(S_MEM_WR); v.ready = 1'b0; v.mw = 1'b1; v.iord = 1'b1;
      vec.push_back(v);
    end
    run_vec("store_prefix");
    i_rst = 1'b1;
    i_mem_ready = 1'b0;
    #1;
    chk("rst_mid_wr_mem_write", 32'(o_mem_write), 32'd0);
    chk("rst_mid_wr_state", 32'(o_state), 32'(S_MEM_WR));
    @(negedge i_clk);
    #1;
    chk("rst_mid_wr_next_state", 32'(o_state), 32'(S_FETCH));
    chk("rst_mid_wr_strobes", 32'({o_mem_read, o_mem_write, o_iord}), 32'd0);
    chk("rst_mid_wr_instret", 32'(o_instret), 32'd0);
    i_rst = 1'b0;
    exp_imm = '0;
    exp_instret = '0;
    gen_instr(OP_STORE, 1, 2, 1'b0);
    gen_instr(OP_JALR, 0, 0, 1'b0);
    run_vec("after_mid_rst");
    #1;
    chk("after_mid_rst_instret", 32'(o_instret), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
